// File: rtl/mcpu_core_scoreboard.sv
// mcpu_core_scoreboard: tracks general registers r0-r31 and predicates p0-p2
// that have a write in flight between issue and writeback. It also flags
// protocol violations with a sticky error bit.
// Optional feature: define MCPU_SB_BYPASS_EN to let a same-cycle writeback
// clear the outputs combinationally. Without it, outputs are registered only.
module mcpu_core_scoreboard (
    input  logic        clkrst_core_clk,
    input  logic        clkrst_core_rst_n,
    input  logic        d2sb_issue0,
    input  logic        d2sb_issue1,
    input  logic [4:0]  d2sb_rd_num0,
    input  logic [4:0]  d2sb_rd_num1,
    input  logic        d2sb_rd_we0,
    input  logic        d2sb_rd_we1,
    input  logic        d2sb_pred_we0,
    input  logic        d2sb_pred_we1,
    input  logic [4:0]  wb2sb_rd_num0,
    input  logic [4:0]  wb2sb_rd_num1,
    input  logic        wb2sb_rd_we0,
    input  logic        wb2sb_rd_we1,
    input  logic        wb2sb_pred_we0,
    input  logic        wb2sb_pred_we1,
    input  logic        pc2sb_flush,
    output logic [31:0] sb2d_reg_scoreboard,
    output logic [2:0]  sb2d_pred_scoreboard,
    output logic        sb_err
);

    // One-hot decode of a register number, gated by its enable.
    function automatic logic [31:0] reg_onehot(input logic en, input logic [4:0] num);
        logic [31:0] v;
        v = '0;
        if (en) v[num] = 1'b1;
        return v;
    endfunction

    // One-hot decode of a predicate index. Index 3 is the constant-true
    // predicate, so it never maps to a tracked bit.
    function automatic logic [2:0] pred_onehot(input logic en, input logic [1:0] idx);
        logic [2:0] v;
        v = '0;
        if (en && idx != 2'd3) v[idx] = 1'b1;
        return v;
    endfunction

    logic [31:0] reg_pend_q, reg_pend_d;
    logic [2:0]  pred_pend_q, pred_pend_d;
    logic        sb_err_q, sb_err_d;

    logic [31:0] reg_set0, reg_set1, reg_set, reg_clr;
    logic [2:0]  pred_set0, pred_set1, pred_set, pred_clr;
    logic        err_now;

    // Decode the set and clear terms for both lanes, then form the next state.
    always_comb begin
        // NOTE: every signal driven here gets a default value first, so no
        // path through the block can leave it unassigned and infer a latch.
        reg_set0    = reg_onehot(d2sb_issue0 & d2sb_rd_we0, d2sb_rd_num0);
        reg_set1    = reg_onehot(d2sb_issue1 & d2sb_rd_we1, d2sb_rd_num1);
        pred_set0   = pred_onehot(d2sb_issue0 & d2sb_pred_we0, d2sb_rd_num0[1:0]);
        pred_set1   = pred_onehot(d2sb_issue1 & d2sb_pred_we1, d2sb_rd_num1[1:0]);
        reg_set     = reg_set0 | reg_set1;
        pred_set    = pred_set0 | pred_set1;
        reg_clr     = reg_onehot(wb2sb_rd_we0, wb2sb_rd_num0)
                    | reg_onehot(wb2sb_rd_we1, wb2sb_rd_num1);
        pred_clr    = pred_onehot(wb2sb_pred_we0, wb2sb_rd_num0[1:0])
                    | pred_onehot(wb2sb_pred_we1, wb2sb_rd_num1[1:0]);

        // Violations: issue to a bit that stays pending, both lanes issuing
        // to the same bit, or a writeback to a bit that is not pending.
        err_now = (|(reg_set & reg_pend_q & ~reg_clr))
                | (|(pred_set & pred_pend_q & ~pred_clr))
                | (|(reg_set0 & reg_set1))
                | (|(pred_set0 & pred_set1))
                | (|(reg_clr & ~reg_pend_q))
                | (|(pred_clr & ~pred_pend_q));

        // Flush wins over set, and set wins over clear.
        if (pc2sb_flush) begin
            reg_pend_d  = '0;
            pred_pend_d = '0;
            sb_err_d    = sb_err_q;
        end else begin
            reg_pend_d  = (reg_pend_q & ~reg_clr) | reg_set;
            pred_pend_d = (pred_pend_q & ~pred_clr) | pred_set;
            sb_err_d    = sb_err_q | err_now;
        end
    end

    // Pending bitmaps and sticky error flag, cleared asynchronously on reset.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, whatever order the statements are in.
        if (!clkrst_core_rst_n) begin
            reg_pend_q  <= '0;
            pred_pend_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            reg_pend_q  <= reg_pend_d;
            pred_pend_q <= pred_pend_d;
            sb_err_q    <= sb_err_d;
        end
    end

`ifdef MCPU_SB_BYPASS_EN
    // Same-cycle writebacks release dependents immediately. Sets are never bypassed.
    assign sb2d_reg_scoreboard  = reg_pend_q & ~reg_clr;
    assign sb2d_pred_scoreboard = pred_pend_q & ~pred_clr;
`else
    // Registered view only. A writeback shows one cycle later.
    assign sb2d_reg_scoreboard  = reg_pend_q;
    assign sb2d_pred_scoreboard = pred_pend_q;
`endif

    assign sb_err = sb_err_q;

endmodule
